// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg : shared VGA mode constants, mode struct and total helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  typedef struct packed {
    int h_visible;
    int h_front;
    int h_sync;
    int h_back;
    int v_visible;
    int v_front;
    int v_sync;
    int v_back;
  } timing_mode_t;

  localparam timing_mode_t DEFAULT_MODE = '{
    h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33
  };

  localparam int DEFAULT_FRAME_CNT_W = 16;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter : one raster axis (H or V) with registered sync/visible.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int VISIBLE = 640,
  parameter  int FRONT   = 16,
  parameter  int SYNC    = 96,
  parameter  int BACK    = 48,
  localparam int TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK),
  localparam int W       = $clog2(TOTAL)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         advance_i,
  input  logic         restart_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         sync_active_o,
  output logic         visible_o
);

  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] C_VIS_END    = W'(VISIBLE);
  localparam logic [W-1:0] C_SYNC_START = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] C_SYNC_END   = W'(VISIBLE + FRONT + SYNC);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, visible_q;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = (count_q == C_LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Flags are decoded from the next count so they line up with count_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      sync_q    <= 1'b0;
      visible_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      sync_q    <= (count_d >= C_SYNC_START) && (count_d < C_SYNC_END);
      visible_q <= (count_d < C_VIS_END);
    end
  end

  assign count_o       = count_q;
  assign wrap_o        = advance_i & ~restart_i & (count_q == C_LAST);
  assign sync_active_o = sync_q;
  assign visible_o     = visible_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_generator_param.sv
// ---------------------------------------------------------------------------
// vga_timing_generator_param : parametrised VGA raster/sync/event generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing_generator_param
  import vga_timing_pkg::*;
#(
  parameter  int H_VISIBLE   = DEFAULT_MODE.h_visible,
  parameter  int H_FRONT     = DEFAULT_MODE.h_front,
  parameter  int H_SYNC      = DEFAULT_MODE.h_sync,
  parameter  int H_BACK      = DEFAULT_MODE.h_back,
  parameter  int V_VISIBLE   = DEFAULT_MODE.v_visible,
  parameter  int V_FRONT     = DEFAULT_MODE.v_front,
  parameter  int V_SYNC      = DEFAULT_MODE.v_sync,
  parameter  int V_BACK      = DEFAULT_MODE.v_back,
  parameter  int HSYNC_POL   = 0,
  parameter  int VSYNC_POL   = 0,
  parameter  int FRAME_CNT_W = DEFAULT_FRAME_CNT_W,
  localparam int H_TOTAL     = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL     = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int XW          = $clog2(H_TOTAL),
  localparam int YW          = $clog2(V_TOTAL)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pix_ce_i,
  input  logic                   enable_i,
  input  logic [YW-1:0]          line_cmp_i,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   blank_n_o,
  output logic [XW-1:0]          x_o,
  output logic [YW-1:0]          y_o,
  output logic                   end_of_line_o,
  output logic                   end_of_frame_o,
  output logic                   line_match_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o
);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      FRAME_CNT_W < 1) begin : g_param_check
    $error("vga_timing_generator_param: every timing parameter must be >= 1");
  end

  localparam logic [XW-1:0] C_X_LAST_VIS = XW'(H_VISIBLE - 1);
  localparam logic [YW-1:0] C_Y_VIS_END  = YW'(V_VISIBLE);
  localparam logic [YW-1:0] C_Y_LAST_VIS = YW'(V_VISIBLE - 1);

  logic                   started_q;
  logic                   eol_q, eof_q, match_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic          w_start, w_step, w_restart;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y, w_y_next;
  logic          w_h_wrap, w_v_wrap, w_h_sync, w_v_sync, w_h_vis, w_v_vis;
  logic          eol_d, eof_d, match_d;

  assign w_start   = enable_i & pix_ce_i & ~started_q;
  assign w_step    = enable_i & pix_ce_i & started_q;
  // Idle and the start tick both park the counters at (0,0).
  assign w_restart = ~(enable_i & started_q);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .advance_i    (w_step),
    .restart_i    (w_restart),
    .count_o      (w_x),
    .wrap_o       (w_h_wrap),
    .sync_active_o(w_h_sync),
    .visible_o    (w_h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .advance_i    (w_h_wrap),
    .restart_i    (w_restart),
    .count_o      (w_y),
    .wrap_o       (w_v_wrap),
    .sync_active_o(w_v_sync),
    .visible_o    (w_v_vis)
  );

  assign w_y_next = w_v_wrap ? '0 : w_y + 1'b1;

  always_comb begin
    eol_d   = w_step && (w_x == C_X_LAST_VIS) && (w_y < C_Y_VIS_END);
    eof_d   = eol_d && (w_y == C_Y_LAST_VIS);
    match_d = (w_start && (line_cmp_i == '0)) ||
              (w_h_wrap && (w_y_next == line_cmp_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_q   <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      match_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      started_q <= enable_i & (started_q | pix_ce_i);
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      match_q   <= match_d;
      if (w_v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign hsync_o        = (HSYNC_POL != 0) ? w_h_sync : ~w_h_sync;
  assign vsync_o        = (VSYNC_POL != 0) ? w_v_sync : ~w_v_sync;
  assign blank_n_o      = started_q & w_h_vis & w_v_vis;
  assign x_o            = w_x;
  assign y_o            = w_y;
  assign end_of_line_o  = eol_q;
  assign end_of_frame_o = eof_q;
  assign line_match_o   = match_q;
  assign frame_count_o  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator_param.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator_param : directed checks on default and small modes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_generator_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic en = 1'b0;
  logic [9:0] d_cmp = '0;
  logic [2:0] s_cmp = 3'd2;

  logic        d_hs, d_vs, d_bn, d_eol, d_eof, d_lm;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;
  logic        s_hs, s_vs, s_bn, s_eol, s_eof, s_lm;
  logic [3:0]  s_x;
  logic [2:0]  s_y;
  logic [15:0] s_fc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_generator_param u_dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(ce), .enable_i(en), .line_cmp_i(d_cmp),
    .hsync_o(d_hs), .vsync_o(d_vs), .blank_n_o(d_bn), .x_o(d_x), .y_o(d_y),
    .end_of_line_o(d_eol), .end_of_frame_o(d_eof), .line_match_o(d_lm),
    .frame_count_o(d_fc)
  );

  vga_timing_generator_param #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(0)
  ) u_small (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(ce), .enable_i(en), .line_cmp_i(s_cmp),
    .hsync_o(s_hs), .vsync_o(s_vs), .blank_n_o(s_bn), .x_o(s_x), .y_o(s_y),
    .end_of_line_o(s_eol), .end_of_frame_o(s_eof), .line_match_o(s_lm),
    .frame_count_o(s_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase-1 observation accumulators
  int d_pos_err = 0, d_hs_first = -1, d_hs_last = -1, d_hs_cnt = 0;
  int d_eol_cnt = 0, d_eol_x = -1, d_eol_y = -1, d_eol_bn = -1, d_eof_cnt = 0, d_lm_cnt = 0;
  int s_pos_err = 0, s_eol_cnt = 0, s_eof_cnt = 0, s_vs_cnt = 0, s_vs_bad = 0;
  int s_hs_cnt = 0, s_hs_bad = 0, s_lm_cnt = 0, s_lm_first = -1, s_bn_bad = 0;

  task automatic observe(input int t);
    int p, sx, sy;
    p  = t % 84;
    sx = p % 12;
    sy = p / 12;
    if (int'(d_x) != t % 800 || int'(d_y) != t / 800) d_pos_err++;
    if (d_hs == 1'b0) begin
      if (d_hs_first < 0) d_hs_first = int'(d_x);
      d_hs_last = int'(d_x);
      d_hs_cnt++;
    end
    if (d_eol) begin
      d_eol_cnt++;
      d_eol_x = int'(d_x);
      d_eol_y = int'(d_y);
      d_eol_bn = int'(d_bn);
    end
    if (d_eof) d_eof_cnt++;
    if (d_lm) d_lm_cnt++;
    if (int'(s_x) != sx || int'(s_y) != sy || int'(s_fc) != t / 84) s_pos_err++;
    if (s_eol) s_eol_cnt++;
    if (s_eof) s_eof_cnt++;
    if (s_vs == 1'b0) s_vs_cnt++;
    if (s_vs !== (sy != 5)) s_vs_bad++;
    if (s_hs == 1'b1) s_hs_cnt++;
    if (s_hs !== (sx >= 9 && sx <= 10)) s_hs_bad++;
    if (s_bn !== (sx < 8 && sy < 4)) s_bn_bad++;
    if (s_lm) begin
      s_lm_cnt++;
      if (s_lm_first < 0) s_lm_first = t;
    end
  endtask

  initial begin
    int ps, td, pos2_err, eol2, eof2, lm2;

    // Reset state
    tick();
    tick();
    chk("rst_d_hsync", d_hs, 1);
    chk("rst_d_vsync", d_vs, 1);
    chk("rst_d_blank_n", d_bn, 0);
    chk("rst_d_x", d_x, 0);
    chk("rst_d_pulses", {d_eol, d_eof, d_lm}, 0);
    chk("rst_d_fc", d_fc, 0);
    chk("rst_s_hsync", s_hs, 0);

    // Enabled, start tick enters (0,0)
    rst_n = 1'b1;
    en = 1'b1;
    ce = 1'b1;
    tick();
    chk("start_d_x", d_x, 0);
    chk("start_d_y", d_y, 0);
    chk("start_d_blank_n", d_bn, 1);
    chk("start_d_line_match_0", d_lm, 1);
    chk("start_s_blank_n", s_bn, 1);
    observe(0);
    for (int t = 1; t < 800; t++) begin
      tick();
      observe(t);
    end
    chk("d_pos_track", d_pos_err, 0);
    chk("d_hsync_first_low", d_hs_first, 656);
    chk("d_hsync_last_low", d_hs_last, 751);
    chk("d_hsync_low_cnt", d_hs_cnt, 96);
    chk("d_eol_cnt", d_eol_cnt, 1);
    chk("d_eol_x", d_eol_x, 640);
    chk("d_eol_y", d_eol_y, 0);
    chk("d_eol_blank_n", d_eol_bn, 0);
    chk("d_eof_cnt", d_eof_cnt, 0);
    chk("d_lm_cnt", d_lm_cnt, 1);
    chk("d_vsync_idle_line0", d_vs, 1);
    chk("s_pos_track", s_pos_err, 0);
    chk("s_eol_cnt", s_eol_cnt, 39);
    chk("s_eof_cnt", s_eof_cnt, 9);
    chk("s_vsync_low_cnt", s_vs_cnt, 108);
    chk("s_vsync_shape", s_vs_bad, 0);
    chk("s_hsync_high_cnt", s_hs_cnt, 132);
    chk("s_hsync_shape", s_hs_bad, 0);
    chk("s_blank_shape", s_bn_bad, 0);
    chk("s_lm_cnt", s_lm_cnt, 10);
    chk("s_lm_first_t", s_lm_first, 24);
    chk("s_fc_after_800", s_fc, 9);

    // Half-rate pixel enable; small mode runs one full frame from p=43
    s_cmp = 3'd7;
    ps = 43;
    td = 799;
    pos2_err = 0;
    eol2 = 0;
    eof2 = 0;
    lm2 = 0;
    for (int i = 0; i < 168; i++) begin
      ce = (i % 2 == 0);
      tick();
      if (i % 2 == 0) begin
        ps = (ps + 1) % 84;
        td++;
      end
      if (int'(s_x) != ps % 12 || int'(s_y) != ps / 12) pos2_err++;
      if (int'(d_x) != td % 800 || int'(d_y) != td / 800) pos2_err++;
      if (s_eol) eol2++;
      if (s_eof) eof2++;
      if (s_lm) lm2++;
    end
    chk("half_pos_hold", pos2_err, 0);
    chk("half_eol_clks", eol2, 4);
    chk("half_eof_clks", eof2, 1);
    chk("half_lm_out_of_range", lm2, 0);
    chk("half_s_fc", s_fc, 10);
    chk("half_d_x", d_x, 83);
    chk("half_d_y", d_y, 1);

    // Drop enable just before end of frame (small at x=7,y=3)
    ce = 1'b1;
    en = 1'b0;
    tick();
    chk("idle_s_x", s_x, 0);
    chk("idle_s_y", s_y, 0);
    chk("idle_s_blank_n", s_bn, 0);
    chk("idle_s_eof", s_eof, 0);
    chk("idle_s_fc", s_fc, 10);
    chk("idle_d_hsync", d_hs, 1);
    tick();
    chk("idle2_s_eof", s_eof, 0);
    chk("idle2_s_fc", s_fc, 10);
    s_cmp = 3'd0;
    en = 1'b1;
    tick();
    chk("restart_s_xy", {s_x, 1'b0, s_y}, 0);
    chk("restart_s_blank_n", s_bn, 1);
    chk("restart_s_lm", s_lm, 1);
    chk("restart_s_fc", s_fc, 10);
    chk("restart_d_x", d_x, 0);
    for (int i = 0; i < 83; i++) tick();
    chk("last_s_x", s_x, 11);
    chk("last_s_y", s_y, 6);
    chk("last_s_fc", s_fc, 10);
    chk("last_s_vsync", s_vs, 1);
    chk("last_s_lm", s_lm, 0);
    tick();
    chk("wrap_s_xy", {s_x, 1'b0, s_y}, 0);
    chk("wrap_s_fc", s_fc, 11);
    chk("wrap_s_lm", s_lm, 1);
    chk("wrap_d_x", d_x, 84);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_s_x", s_x, 5);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_s_x", s_x, 0);
    chk("arst_s_fc", s_fc, 0);
    chk("arst_s_blank_n", s_bn, 0);
    chk("arst_s_hsync", s_hs, 0);
    chk("arst_d_x", d_x, 0);
    chk("arst_d_fc", d_fc, 0);
    chk("arst_d_hsync", d_hs, 1);
    chk("arst_d_blank_n", d_bn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_generator_param.md
Name: vga_timing_generator_param

Overview:
Parametrised successor to the fixed 640x480 VGA timing generator. Per-mode H/V timing, sync polarity and a pixel-clock enable are configurable. It also provides pixel coordinates, a raster-line compare pulse and a frame counter. It drives the video scan-out path and display-list/interrupt logic in place of the fixed-mode generator.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync_o (0 = active-low)
VSYNC_POL, 0, active level of vsync_o
FRAME_CNT_W, 16, width of frame_count_o

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous assert, active-low
pix_ce_i  in  1  pixel tick; the raster advances only on cycles where this is 1
enable_i  in  1  run; 0 = hold in idle state
line_cmp_i  in  YW  raster-compare line number
hsync_o  out  1  horizontal sync, polarity HSYNC_POL
vsync_o  out  1  vertical sync, polarity VSYNC_POL
blank_n_o  out  1  1 inside the visible area
x_o  out  XW  current pixel column
y_o  out  YW  current line
end_of_line_o  out  1  one-clk pulse: first pixel after the visible part of a visible line
end_of_frame_o  out  1  one-clk pulse: first pixel after the last visible pixel of a frame
line_match_o  out  1  one-clk pulse: start of line line_cmp_i
frame_count_o  out  FRAME_CNT_W  completed frames, modulo 2^FRAME_CNT_W

Behaviour:
- Totals: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK; V_TOTAL defined likewise. XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL).
- Any parameter < 1 is an elaboration error.
- Internal state: position (x, y) and a started flag.
- Reset and idle state: started = 0; all outputs in the inactive state (hsync/vsync at ~POL, blank_n_o = 0, x_o = y_o = 0, pulses = 0).
- Reset clears frame_count_o to 0. Idle (enable_i = 0) holds frame_count_o.
- Advance rule: on a clock with enable_i & pix_ce_i:
  - If not started: enter (0,0) and set started.
  - Otherwise x increments. x wraps from H_TOTAL-1 to 0, and on that wrap y increments. y wraps from V_TOTAL-1 to 0.
- All outputs are registered and describe the position just entered, so every output is aligned with x_o/y_o with 0 relative latency.
- Outputs hold between pixel ticks.
- Pulses are asserted only on the clk cycle the triggering position is entered. They are exactly 1 clk wide whatever the pix_ce_i duty cycle.
- hsync active iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
- vsync active iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC. vsync therefore changes only at x = 0.
- blank_n_o = (x < H_VISIBLE) && (y < V_VISIBLE).
- end_of_line_o: entering (H_VISIBLE, y) with y < V_VISIBLE.
- end_of_frame_o: entering (H_VISIBLE, V_VISIBLE-1). On that cycle end_of_line_o is also asserted.
- line_match_o: entering (0, line_cmp_i). line_cmp_i is sampled on that cycle. A value >= V_TOTAL never matches.
- frame_count_o: increments on a wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0). The first entry to (0,0) after start does not count.
- enable_i falling mid-frame: next clk returns to idle. No end-of-frame pulse, frame count unchanged. Re-enable restarts at (0,0).
- rst_ni assert mid-frame: outputs go to reset values immediately, without a clock edge. Release is synchronised by the integrator.

Decomposition:
- Package vga_timing_pkg holds:
  - default mode constants (640x480@60);
  - a timing_mode_t struct holding the eight timing values, for passing modes between blocks;
  - a function computing totals.
- Sub-module vga_axis_counter, instantiated once for H and once for V. Parameters: VISIBLE, FRONT, SYNC, BACK. Inputs: advance, restart. Outputs: count, wrap, sync_active, visible.

Test Plan:
- Defaults, reset then pix_ce_i = 1 constantly, enable_i = 1:
  - first tick gives x_o = 0, y_o = 0, blank_n_o = 1;
  - hsync_o low for x = 656..751, high again at 752;
  - end_of_line_o pulses at (640,0).
- Defaults, run 2 frames (840000 ticks):
  - end_of_frame_o exactly once per frame, at (640,479);
  - vsync_o low for exactly 1600 ticks (y = 490..491);
  - frame_count_o goes 0 -> 1 at the second entry to (0,0);
  - line period 800 ticks, frame period 420000 ticks.
- pix_ce_i asserted every 2nd clk: positions advance at half rate, each pulse is still 1 clk wide, outputs hold on non-tick cycles.
- line_cmp_i = 100: line_match_o exactly once per frame at (0,100). line_cmp_i = 600: never asserted.
- Small mode (H 8/1/2/1, V 4/1/1/1, HSYNC_POL = 1):
  - H_TOTAL = 12, V_TOTAL = 7, frame period 84 ticks;
  - hsync_o high for x = 9..10;
  - vsync_o low on y = 5 only.
- Interruptions:
  - enable_i dropped at (300,200) then raised: no end_of_frame_o, frame_count_o unchanged, restart at (0,0).
  - rst_ni asserted between clock edges: outputs at reset values before the next edge.
